traffic_phase_timer: RTL and testbench
======================================

TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

Interface
REQ-001 Parameter CW, default 4: phase counter width in bits.
REQ-002 Parameter RED_T, default 10: red phase length in enabled ticks.
REQ-003 Parameter GREEN_T, default 8: full green phase length in enabled ticks.
REQ-004 Parameter AMBER_T, default 4: amber phase length in enabled ticks.
REQ-005 Parameter GREEN_MIN, default 2: minimum green ticks before a pedestrian request may cut green short.
REQ-006 second_clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-low reset; only 0 at a rising edge of second_clk resets the block.
REQ-008 enable  input  1  tick qualifier; timing advances only on edges where enable=1.
REQ-009 pedestrian  input  1  pedestrian request; level or pulse, sampled every edge.
REQ-010 currColour  output  2  current phase: 00 red, 01 amber, 11 green; 10 never driven.
REQ-011 counter_reg  output  CW  ticks elapsed in current phase.
REQ-012 phase_done  output  1  one-cycle pulse on the edge that changes phase.
REQ-013 ped_pending  output  1  latched, unserved pedestrian request.
REQ-014 walk  output  1  walk indication for pedestrians during red.

Function
REQ-015 Phase sequence SHALL be red -> green -> amber -> red only; no other transitions.
REQ-016 On an edge with enable=1, a phase of length T SHALL advance counter_reg by 1 while counter_reg < T-1.
REQ-017 On the first enabled edge with counter_reg = T-1, the block SHALL load the next phase, clear counter_reg to 0 and assert phase_done for that cycle only.
REQ-018 On edges with enable=0, currColour, counter_reg and walk SHALL hold, phase_done SHALL be 0, and pedestrian latching SHALL still occur.
REQ-019 If pedestrian=1 at any edge, ped_pending SHALL be 1 after that edge, except as given by REQ-022.
REQ-020 In green, on an enabled edge with ped_pending=1 and counter_reg >= GREEN_MIN-1, the block SHALL go to amber, clear counter_reg and pulse phase_done.
REQ-021 In amber, a pedestrian request SHALL be latched only; amber timing SHALL be unaffected.
REQ-022 On the edge that enters red, walk SHALL load (ped_pending OR pedestrian) and ped_pending SHALL clear to 0; entry to red takes priority over a same-edge request.
REQ-023 walk SHALL stay constant for the whole red phase and clear to 0 on the edge leaving red.
REQ-024 A request arriving during red after entry SHALL stay pending and be served by the next green/red cycle.
REQ-025 All parameters SHALL satisfy 1 <= value <= 2^CW and GREEN_MIN <= GREEN_T; a violation SHALL stop elaboration.

Reset
REQ-026 When reset=0 at an edge, outputs SHALL become: currColour=00, counter_reg=0, phase_done=0, ped_pending=0, walk=0.
REQ-027 Reset SHALL override enable and pedestrian, and SHALL abort any phase mid-count.
REQ-028 The first enabled edge after reset release SHALL produce counter_reg=1 in red.

Verification
REQ-029 Defaults, enable=1, no pedestrian: red shows counter 0..9, green 0..7, amber 0..3, then red; period is 22 cycles; phase_done pulses exactly three times per period.
REQ-030 Pedestrian pulse at green counter_reg=3: green ends after counter_reg=4, followed by a full 4-cycle amber; red then has walk=1 for 10 cycles and ped_pending=0.
REQ-031 Pedestrian held through green counter_reg=0: green lasts exactly 2 cycles (GREEN_MIN) before amber.
REQ-032 Pedestrian at amber counter_reg=1: amber still lasts 4 cycles; walk=1 throughout the following red.
REQ-033 enable=0 for 5 cycles at red counter_reg=6, with a pedestrian pulse inside that window: counter_reg holds at 6, phase_done=0, ped_pending becomes 1; counting resumes at 7.
REQ-034 reset=0 for one edge at green counter_reg=5 with ped_pending=1: next state is red, counter_reg=0, ped_pending=0, walk=0.

Source files
------------

// File: rtl/traffic_phase_timer.sv
// Red/green/amber phase sequencer with per-phase tick counter, pedestrian
// request latch that can cut green short, and a walk flag held through red.
module traffic_phase_timer #(
    parameter int CW        = 4,
    parameter int RED_T     = 10,
    parameter int GREEN_T   = 8,
    parameter int AMBER_T   = 4,
    parameter int GREEN_MIN = 2
) (
    input  logic          second_clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          pedestrian,
    output logic [1:0]    currColour,
    output logic [CW-1:0] counter_reg,
    output logic          phase_done,
    output logic          ped_pending,
    output logic          walk
);

    // state | meaning
    // RED   | stop for traffic; walk shown if a request was latched on entry
    // GREEN | traffic flows; may end early once GREEN_MIN ticks have elapsed
    // AMBER | fixed-length warning before red; requests only latched

    if (CW < 1 || CW > 31 ||
        RED_T < 1 || RED_T > 2**CW ||
        GREEN_T < 1 || GREEN_T > 2**CW ||
        AMBER_T < 1 || AMBER_T > 2**CW ||
        GREEN_MIN < 1 || GREEN_MIN > 2**CW ||
        GREEN_MIN > GREEN_T) begin : g_param_check
        $fatal(1, "traffic_phase_timer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        RED   = 2'b00,
        AMBER = 2'b01,
        GREEN = 2'b11
    } colour_t;

    localparam logic [CW-1:0] RED_LAST   = CW'(RED_T - 1);
    localparam logic [CW-1:0] GREEN_LAST = CW'(GREEN_T - 1);
    localparam logic [CW-1:0] AMBER_LAST = CW'(AMBER_T - 1);
    localparam logic [CW-1:0] GMIN_LAST  = CW'(GREEN_MIN - 1);

    colour_t phase;

    assign currColour = phase;

    always_ff @(posedge second_clk) begin
        if (!reset) begin
            phase       <= RED;
            counter_reg <= '0;
            phase_done  <= 1'b0;
            ped_pending <= 1'b0;
            walk        <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            if (pedestrian)
                ped_pending <= 1'b1;
            if (enable) begin
                case (phase)
                    RED: begin
                        if (counter_reg == RED_LAST) begin
                            phase       <= GREEN;
                            counter_reg <= '0;
                            phase_done  <= 1'b1;
                            walk        <= 1'b0;
                        end else begin
                            counter_reg <= counter_reg + CW'(1);
                        end
                    end
                    GREEN: begin
                        // The pending flag seen here is the pre-edge value, so a
                        // request only shortens green from the following tick on.
                        if (counter_reg == GREEN_LAST ||
                            (ped_pending && counter_reg >= GMIN_LAST)) begin
                            phase       <= AMBER;
                            counter_reg <= '0;
                            phase_done  <= 1'b1;
                        end else begin
                            counter_reg <= counter_reg + CW'(1);
                        end
                    end
                    AMBER: begin
                        if (counter_reg == AMBER_LAST) begin
                            phase       <= RED;
                            counter_reg <= '0;
                            phase_done  <= 1'b1;
                            walk        <= ped_pending | pedestrian;
                            ped_pending <= 1'b0;
                        end else begin
                            counter_reg <= counter_reg + CW'(1);
                        end
                    end
                    default: begin
                        phase       <= RED;
                        counter_reg <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Scoreboarded bench: directed scenarios then random stimulus, checked every
// edge against a phase-duration reference model.
module tb_traffic_phase_timer;

    localparam int CW        = 4;
    localparam int RED_T     = 10;
    localparam int GREEN_T   = 8;
    localparam int AMBER_T   = 4;
    localparam int GREEN_MIN = 2;

    typedef struct packed {
        logic [1:0]    col;
        logic [CW-1:0] cnt;
        logic          done;
        logic          pend;
        logic          walk;
    } obs_t;

    logic          second_clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          pedestrian = 1'b0;
    logic [1:0]    currColour;
    logic [CW-1:0] counter_reg;
    logic          phase_done;
    logic          ped_pending;
    logic          walk;

    traffic_phase_timer #(
        .CW(CW), .RED_T(RED_T), .GREEN_T(GREEN_T),
        .AMBER_T(AMBER_T), .GREEN_MIN(GREEN_MIN)
    ) dut (
        .second_clk (second_clk),
        .reset      (reset),
        .enable     (enable),
        .pedestrian (pedestrian),
        .currColour (currColour),
        .counter_reg(counter_reg),
        .phase_done (phase_done),
        .ped_pending(ped_pending),
        .walk       (walk)
    );

    always #5 second_clk = ~second_clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   dut_done_count = 0;
    obs_t exp_q[$];

    // Reference model: phase index 0=red 1=green 2=amber
    int   m_phase = 0;
    int   m_cnt = 0;
    bit   m_pend = 0;
    bit   m_walk = 0;
    bit   m_done = 0;
    int   phase_len[3] = '{RED_T, GREEN_T, AMBER_T};
    logic [1:0] phase_code[3] = '{2'b00, 2'b11, 2'b01};

    task automatic model_step(input bit r, input bit e, input bit p);
        bit new_pend;
        bit cut;
        if (!r) begin
            m_phase = 0; m_cnt = 0; m_pend = 0; m_walk = 0; m_done = 0;
        end else begin
            m_done   = 0;
            new_pend = m_pend | p;
            if (e) begin
                cut = (m_phase == 1) && m_pend && (m_cnt >= GREEN_MIN - 1);
                if (m_cnt == phase_len[m_phase] - 1 || cut) begin
                    m_done  = 1;
                    m_cnt   = 0;
                    m_phase = (m_phase + 1) % 3;
                    if (m_phase == 0) begin
                        m_walk   = m_pend | p;
                        new_pend = 0;
                    end else if (m_phase == 1) begin
                        m_walk = 0;
                    end
                end else begin
                    m_cnt++;
                end
            end
            m_pend = new_pend;
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit p);
        obs_t x;
        reset = r; enable = e; pedestrian = p;
        model_step(r, e, p);
        x.col  = phase_code[m_phase];
        x.cnt  = CW'(m_cnt);
        x.done = m_done;
        x.pend = m_pend;
        x.walk = m_walk;
        exp_q.push_back(x);
        @(negedge second_clk);
    endtask

    task automatic run_until(input int ph, input int c, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (m_phase == ph && m_cnt == c) return;
            cyc(1, 1, 0);
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: timeout waiting for phase %0d count %0d (at phase %0d count %0d)",
                 tag, ph, c, m_phase, m_cnt);
    endtask

    initial begin : monitor
        obs_t act;
        obs_t exp_v;
        forever begin
            @(posedge second_clk);
            #1;
            act = '{currColour, counter_reg, phase_done, ped_pending, walk};
            if (act.done === 1'b1) dut_done_count++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard: DUT output %h with no expected entry", act);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    miscompares++;
                    $display("FAIL cycle_check t=%0t: got col=%b cnt=%0d done=%b pend=%b walk=%b, want col=%b cnt=%0d done=%b pend=%b walk=%b",
                             $time, act.col, act.cnt, act.done, act.pend, act.walk,
                             exp_v.col, exp_v.cnt, exp_v.done, exp_v.pend, exp_v.walk);
                end
            end
        end
    end

    initial begin : stimulus
        cyc(0, 1, 1);
        cyc(0, 0, 0);

        // Undisturbed period: three phase_done pulses in 22 enabled edges
        dut_done_count = 0;
        for (int i = 0; i < 22; i++) cyc(1, 1, 0);
        vectors++;
        if (dut_done_count != 3) begin
            miscompares++;
            $display("FAIL period_done_pulses: got %0d, want 3", dut_done_count);
        end

        // Pulse at green count 3 cuts green after count 4
        run_until(1, 3, "ped_green3");
        cyc(1, 1, 1);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0);

        // Request held through green count 0: green lasts GREEN_MIN ticks
        run_until(0, RED_T - 1, "ped_held");
        cyc(1, 1, 1);
        cyc(1, 1, 1);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0);

        // Request in amber: amber unchanged, walk through next red
        run_until(2, 1, "ped_amber");
        cyc(1, 1, 1);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0);

        // Enable gap at red count 6 with a request inside the gap
        run_until(0, 6, "enable_gap");
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 0); cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0);

        // Reset at green count 5 with a pending request
        run_until(1, 4, "reset_green5");
        cyc(1, 1, 1);
        cyc(0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(99) != 0), ($urandom_range(3) != 0),
                ($urandom_range(11) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
